// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback requesters,
// with a per-register busy scoreboard that exports RAW hazard and WAW issue-ready flags.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 wb_write_en,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic                 issue_ready,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [31:0]     busy_q, busy_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_we_q, wb_we_d;

    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Search begins one past the last winner so every requester is reached within NREQ grants.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_rd   = req_rd[int'(grant_idx)*5 +: 5];
    assign sel_data = req_data[int'(grant_idx)*XLEN +: XLEN];

    always_comb begin
        ptr_d     = grant_any ? grant_idx : ptr_q;
        wb_we_d   = grant_any && (sel_rd != 5'd0);
        wb_rd_d   = grant_any ? sel_rd : wb_rd_q;
        wb_data_d = grant_any ? sel_data : wb_data_q;

        // Clear first so a same-edge dispatch to the same rd leaves it busy.
        busy_d = busy_q;
        if (wb_we_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q     <= PW'(NREQ - 1);
            busy_q    <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
        end
    end

    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_write_en = wb_we_q;
    assign issue_ready = !busy_q[issue_rd];
    assign rs1_busy    = busy_q[rs1];
    assign rs2_busy    = busy_q[rs2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writebacks are queued at grant time
// and matched by an independent monitor that watches the register-file write port.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NREQ = 2;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 wb_write_en;
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic                 issue_ready;
    logic [4:0]           rs1, rs2;
    logic                 rs1_busy, rs2_busy;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_write_en(wb_write_en),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every register-file write must match the oldest queued grant, in the right cycle.
    always @(negedge clock) begin
        if (wb_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_rd", {59'd0, wb_rd}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
                chk("wb_data", {32'd0, wb_data}, {32'd0, e.data});
                chk("wb_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called after inputs are set and before the edge that would accept the request.
    task automatic expect_grant(input int idx, input logic [4:0] rd, input logic [XLEN-1:0] data);
        exp_t e;
        chk("req_ready", {62'd0, req_ready}, 64'(1 << idx));
        if (rd != 5'd0) begin
            e.rd   = rd;
            e.data = data;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        #1;
        chk("issue_ready_on_dispatch", {63'd0, issue_ready}, 64'd1);
        step();
        issue_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;

        // Reset then idle
        step();
        step();
        reset_n = 1'b1;
        rs1 = 5'd9;
        rs2 = 5'd10;
        issue_rd = 5'd11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_we", {63'd0, wb_write_en}, 64'd0);
            chk("idle_ready", {62'd0, req_ready}, 64'd0);
            chk("idle_rs1_busy", {63'd0, rs1_busy}, 64'd0);
            chk("idle_rs2_busy", {63'd0, rs2_busy}, 64'd0);
            chk("idle_issue_ready", {63'd0, issue_ready}, 64'd1);
        end

        // Contention: both requesters continuously valid, pointer fresh from reset
        issue(5'd1);
        issue(5'd2);
        req_rd = {5'd2, 5'd1};
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            req_data = {32'h2000_0000 | 32'(g), 32'h1000_0000 | 32'(g)};
            #1;
            if (g % 2 == 0) expect_grant(0, 5'd1, 32'h1000_0000 | 32'(g));
            else            expect_grant(1, 5'd2, 32'h2000_0000 | 32'(g));
            step();
        end
        req_valid = '0;
        step();
        step();

        // Single path, including no-forwarding during the write cycle
        issue(5'd5);
        rs1 = 5'd5;
        #1;
        chk("rs1_busy_after_issue", {63'd0, rs1_busy}, 64'd1);
        req_valid = 2'b01;
        req_rd    = {5'd0, 5'd5};
        req_data  = {32'h0, 32'hDEAD_BEEF};
        #1;
        expect_grant(0, 5'd5, 32'hDEAD_BEEF);
        step();
        req_valid = '0;
        #1;
        chk("rs1_busy_during_write", {63'd0, rs1_busy}, 64'd1);
        step();
        chk("rs1_busy_after_write", {63'd0, rs1_busy}, 64'd0);
        chk("hold_we", {63'd0, wb_write_en}, 64'd0);
        chk("hold_wb_data", {32'd0, wb_data}, {32'd0, 32'hDEAD_BEEF});
        chk("hold_wb_rd", {59'd0, wb_rd}, 64'd5);

        // x0 request: accepted, no write, never busy
        req_valid = 2'b10;
        req_rd    = {5'd0, 5'd0};
        req_data  = {32'h1234_5678, 32'h0};
        #1;
        expect_grant(1, 5'd0, 32'h0);
        step();
        req_valid = '0;
        rs1 = 5'd0;
        issue_rd = 5'd0;
        #1;
        chk("x0_we", {63'd0, wb_write_en}, 64'd0);
        chk("x0_rs1_busy", {63'd0, rs1_busy}, 64'd0);
        chk("x0_issue_ready", {63'd0, issue_ready}, 64'd1);
        step();

        // WAW on rd=7
        issue(5'd7);
        issue_rd = 5'd7;
        #1;
        chk("waw_blocked", {63'd0, issue_ready}, 64'd0);
        req_valid = 2'b01;
        req_rd    = {5'd0, 5'd7};
        req_data  = {32'h0, 32'h0000_0077};
        #1;
        expect_grant(0, 5'd7, 32'h0000_0077);
        step();
        req_valid = '0;
        #1;
        chk("waw_blocked_during_write", {63'd0, issue_ready}, 64'd0);
        step();
        chk("waw_released", {63'd0, issue_ready}, 64'd1);

        // Set/clear collision on rd=3
        req_valid = 2'b10;
        req_rd    = {5'd3, 5'd0};
        req_data  = {32'h0000_0033, 32'h0};
        #1;
        expect_grant(1, 5'd3, 32'h0000_0033);
        step();
        req_valid = '0;
        issue(5'd3);
        rs2 = 5'd3;
        #1;
        chk("collision_set_wins", {63'd0, rs2_busy}, 64'd1);

        // Reset mid-operation with busy[4] set and a grant pending
        issue(5'd4);
        rs1 = 5'd4;
        #1;
        chk("rs1_busy_rd4", {63'd0, rs1_busy}, 64'd1);
        req_valid = 2'b10;
        req_rd    = {5'd4, 5'd0};
        req_data  = {32'h0000_0044, 32'h0};
        reset_n   = 1'b0;
        step();
        reset_n   = 1'b1;
        req_valid = 2'b11;
        req_rd    = {5'd0, 5'd0};
        #1;
        chk("rst_we", {63'd0, wb_write_en}, 64'd0);
        chk("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
        chk("rst_rs2_busy", {63'd0, rs2_busy}, 64'd0);
        chk("rst_priority", {62'd0, req_ready}, 64'd1);
        req_valid = '0;
        step();
        step();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
